// File: rtl/cordic_atan_radian_table_pkg.sv
// atan(2^-i) in radians, truncated to 30 fractional bits, for i = 0..29.
package cordic_atan_radian_table_pkg;

  function automatic logic [31:0] atan_q30(input logic [4:0] idx);
    case (idx)
      5'd0:  return 32'h3243_F6A8;
      5'd1:  return 32'h1DAC_6705;
      5'd2:  return 32'h0FAD_BAFC;
      5'd3:  return 32'h07F5_6EA6;
      5'd4:  return 32'h03FE_AB76;
      5'd5:  return 32'h01FF_D55B;
      5'd6:  return 32'h00FF_FAAA;
      5'd7:  return 32'h007F_FF55;
      5'd8:  return 32'h003F_FFEA;
      5'd9:  return 32'h001F_FFFD;
      5'd10: return 32'h000F_FFFF;
      5'd11: return 32'h0007_FFFF;
      5'd12: return 32'h0003_FFFF;
      5'd13: return 32'h0001_FFFF;
      5'd14: return 32'h0000_FFFF;
      5'd15: return 32'h0000_7FFF;
      5'd16: return 32'h0000_3FFF;
      5'd17: return 32'h0000_1FFF;
      5'd18: return 32'h0000_0FFF;
      5'd19: return 32'h0000_07FF;
      5'd20: return 32'h0000_03FF;
      5'd21: return 32'h0000_01FF;
      5'd22: return 32'h0000_00FF;
      5'd23: return 32'h0000_007F;
      5'd24: return 32'h0000_003F;
      5'd25: return 32'h0000_001F;
      5'd26: return 32'h0000_000F;
      5'd27: return 32'h0000_0007;
      5'd28: return 32'h0000_0003;
      5'd29: return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/cordic_axi4s_types_pkg.sv
// Shared types and Q-format constants for the CORDIC AXI4-Stream engines.
// Constants carry 30 fractional bits; engines round them to their own Q(N-4).
package cordic_axi4s_types_pkg;

  typedef enum logic {
    CORDIC_SINE_COSINE_E = 1'b0,
    CORDIC_RESERVED_E    = 1'b1
  } cordic_tuser_e;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    ROTATE,
    OUTPUT
  } cordic_state_e;

  localparam int          CONST_FRAC_W  = 30;
  localparam logic [35:0] CORDIC_GAIN_Q = 36'h0_26DD_3B6A;
  localparam logic [35:0] PI_Q          = 36'h0_C90F_DAA2;
  localparam logic [35:0] PI_HALF_Q     = 36'h0_6487_ED51;
  localparam logic [35:0] PI2_Q         = 36'h1_921F_B544;

endpackage

// File: rtl/cordic_iterative_sincos_if.sv
// AXI4-Stream ingress (angle) and egress ({sine, cosine}) bundle of the CORDIC engine.
interface cordic_iterative_sincos_if #(
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_ID_WIDTH_P   = 4
);
  logic                          ing_tvalid;
  logic                          ing_tready;
  logic [AXI_DATA_WIDTH_P-1:0]   ing_tdata;
  logic                          ing_tlast;
  logic [AXI_ID_WIDTH_P-1:0]     ing_tid;
  logic                          ing_tuser;
  logic                          egr_tvalid;
  logic                          egr_tready;
  logic [2*AXI_DATA_WIDTH_P-1:0] egr_tdata;
  logic                          egr_tlast;
  logic [AXI_ID_WIDTH_P-1:0]     egr_tid;

  modport master (
    output ing_tvalid, ing_tdata, ing_tlast, ing_tid, ing_tuser, egr_tready,
    input  ing_tready, egr_tvalid, egr_tdata, egr_tlast, egr_tid
  );

  modport slave (
    input  ing_tvalid, ing_tdata, ing_tlast, ing_tid, ing_tuser, egr_tready,
    output ing_tready, egr_tvalid, egr_tdata, egr_tlast, egr_tid
  );
endinterface

// File: rtl/cordic_iterative_sincos.sv
// Single-rotator rotation-mode CORDIC: one angle in, {sine, cosine} out, one micro-rotation per clock.
// Supports N up to 34 (CQ up to 30), the precision of the shared constant tables.
module cordic_iterative_sincos
  import cordic_axi4s_types_pkg::*;
  import cordic_atan_radian_table_pkg::*;
#(
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_ID_WIDTH_P   = 4,
  parameter int NR_OF_STAGES_P   = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  cordic_iterative_sincos_if.slave bus
);

  localparam int N  = AXI_DATA_WIDTH_P;
  localparam int CQ = N - 4;
  localparam int W  = N + 2;
  localparam int SH = CONST_FRAC_W - CQ;

  function automatic logic signed [W-1:0] q_round(input logic [35:0] c);
    logic [35:0] r;
    r = (c + ((36'd1 << SH) >> 1)) >> SH;
    return r[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] atan_q(input logic [4:0] idx);
    logic [31:0] a;
    a = atan_q30(idx) >> SH;
    return W'(a);
  endfunction

  function automatic logic [N-1:0] sat(input logic signed [W-1:0] v);
    if ((&v[W-1:N-1]) || !(|v[W-1:N-1])) return v[N-1:0];
    return v[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction

  localparam logic signed [W-1:0] K_S       = q_round(CORDIC_GAIN_Q);
  localparam logic signed [W-1:0] PI_S      = q_round(PI_Q);
  localparam logic signed [W-1:0] PI_HALF_S = q_round(PI_HALF_Q);
  localparam logic signed [W-1:0] PI2_S     = q_round(PI2_Q);

  cordic_state_e             state, state_next;
  logic                      ing_rdy, egr_vld, egr_last;
  logic [2*N-1:0]            egr_data;
  logic [AXI_ID_WIDTH_P-1:0] egr_id;
  logic [4:0]                i_cnt;
  logic signed [W-1:0]       x, y, z;
  logic                      neg, neg_red, accept, egr_fire, d_pos;
  logic signed [W-1:0]       t_wrap, z_red, x_rot, y_rot, z_rot, at;

  // Range reduction: wrap into [-pi, pi], then fold into [-pi/2, pi/2] with a sign flip
  always_comb begin
    t_wrap = z;
    if (z > PI_S)       t_wrap = z - PI2_S;
    else if (z < -PI_S) t_wrap = z + PI2_S;
    z_red   = t_wrap;
    neg_red = 1'b0;
    if (t_wrap > PI_HALF_S) begin
      z_red   = t_wrap - PI_S;
      neg_red = 1'b1;
    end else if (t_wrap < -PI_HALF_S) begin
      z_red   = t_wrap + PI_S;
      neg_red = 1'b1;
    end
  end

  always_comb begin
    d_pos = ~z[W-1];
    at    = atan_q(i_cnt);
    x_rot = d_pos ? x - (y >>> i_cnt) : x + (y >>> i_cnt);
    y_rot = d_pos ? y + (x >>> i_cnt) : y - (x >>> i_cnt);
    z_rot = d_pos ? z - at : z + at;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    egr_fire   = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.ing_tvalid && ing_rdy;
        if (accept) state_next = REDUCE;
      end
      REDUCE: state_next = ROTATE;
      ROTATE: if (i_cnt == 5'(NR_OF_STAGES_P - 1)) state_next = OUTPUT;
      OUTPUT: begin
        egr_fire = egr_vld && bus.egr_tready;
        if (egr_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ing_tuser selects nothing here: sine and cosine are always produced together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ing_rdy  <= 1'b0;
      egr_vld  <= 1'b0;
      egr_data <= '0;
      egr_id   <= '0;
      egr_last <= 1'b0;
      i_cnt    <= '0;
    end else begin
      state   <= state_next;
      ing_rdy <= (state_next == IDLE);
      if (accept) begin
        egr_id   <= bus.ing_tid;
        egr_last <= bus.ing_tlast;
      end
      if (state == REDUCE)      i_cnt <= '0;
      else if (state == ROTATE) i_cnt <= i_cnt + 5'd1;
      if (state == OUTPUT && !egr_vld) begin
        egr_vld  <= 1'b1;
        egr_data <= {sat(neg ? -y : y), sat(neg ? -x : x)};
      end else if (egr_fire) begin
        egr_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (accept) z <= {{2{bus.ing_tdata[N-1]}}, bus.ing_tdata};
      REDUCE: begin
        x   <= K_S;
        y   <= '0;
        z   <= z_red;
        neg <= neg_red;
      end
      ROTATE: begin
        x <= x_rot;
        y <= y_rot;
        z <= z_rot;
      end
      default: ;
    endcase
  end

  assign bus.ing_tready = ing_rdy;
  assign bus.egr_tvalid = egr_vld;
  assign bus.egr_tdata  = egr_data;
  assign bus.egr_tid    = egr_id;
  assign bus.egr_tlast  = egr_last;

endmodule

// File: tb/tb_cordic_iterative_sincos.sv
// Directed and short random bench for the iterative CORDIC sine/cosine engine.
module tb_cordic_iterative_sincos;

  localparam int     N   = 32;
  localparam int     IDW = 4;
  localparam int     NR  = 16;
  localparam longint ONE = 64'sh1000_0000;
  localparam longint TOL = 64'sd16384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_iterative_sincos_if #(.AXI_DATA_WIDTH_P(N), .AXI_ID_WIDTH_P(IDW)) bus ();

  cordic_iterative_sincos #(
    .AXI_DATA_WIDTH_P(N),
    .AXI_ID_WIDTH_P  (IDW),
    .NR_OF_STAGES_P  (NR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int beats = 0;
  int accepts = 0;

  always @(posedge clk) begin
    if (bus.ing_tvalid && bus.ing_tready) accepts <= accepts + 1;
    if (bus.egr_tvalid && bus.egr_tready) beats <= beats + 1;
  end

  task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
    longint diff;
    n_cmp++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) tol %0d", tag, obs, obs, exp, exp, tol);
    end
  endtask

  function automatic longint sin_of(input logic [63:0] d);
    return longint'($signed(d[63:32]));
  endfunction

  function automatic longint cos_of(input logic [63:0] d);
    return longint'($signed(d[31:0]));
  endfunction

  task automatic send(input logic [31:0] th, input logic [3:0] id, input logic tl);
    int w = 0;
    while (!bus.ing_tready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("ing_ready_wait", longint'(w < 200), 1);
    bus.ing_tvalid = 1'b1;
    bus.ing_tdata  = th;
    bus.ing_tid    = id;
    bus.ing_tlast  = tl;
    @(posedge clk); #1;
    bus.ing_tvalid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.egr_tvalid && lat < 100);
    if (!bus.egr_tvalid) check("egr_timeout", bus.egr_tvalid, 1);
  endtask

  task automatic take();
    bus.egr_tready = 1'b1;
    @(posedge clk); #1;
    bus.egr_tready = 1'b0;
  endtask

  task automatic run_dir(input string tag, input logic [31:0] th, input longint es, input longint ec);
    int lat;
    send(th, 4'h0, 1'b0);
    wait_out(lat);
    check({tag, "_lat"}, lat, NR + 2);
    check({tag, "_sin"}, sin_of(bus.egr_tdata), es, TOL);
    check({tag, "_cos"}, cos_of(bus.egr_tdata), ec, TOL);
    take();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          seen;
    logic [63:0] first;
    bus.ing_tvalid = 1'b0;
    bus.ing_tdata  = '0;
    bus.ing_tid    = '0;
    bus.ing_tlast  = 1'b0;
    bus.ing_tuser  = 1'b0;
    bus.egr_tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ing_tready", bus.ing_tready, 0);
    check("rst_egr_tvalid", bus.egr_tvalid, 0);
    check("rst_egr_tdata", longint'(bus.egr_tdata != 64'd0), 0);
    check("rst_egr_tid", bus.egr_tid, 0);
    check("rst_egr_tlast", bus.egr_tlast, 0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", bus.ing_tready, 0);
    @(posedge clk); #1;
    check("ready_after_edge", bus.ing_tready, 1);

    // Directed angles with hand-computed results
    run_dir("zero",       32'h0000_0000, 0,             ONE);
    run_dir("pi_half",    32'h1921_FB54, ONE,           0);
    run_dir("pi",         32'h3243_F6A9, 0,             -ONE);
    run_dir("three_pi_2", 32'h4B65_F1FD, -ONE,          0);
    run_dir("pi_quarter", 32'h0C90_FDAA, 64'sh0B50_4F33, 64'sh0B50_4F33);
    run_dir("pi_sixth",   32'h0860_A91C, 64'sh0800_0000, 64'sh0DDB_3D74);
    run_dir("neg_pi",     32'hCDBC_0957, 0,             -ONE);
    run_dir("neg_two_pi", 32'h9B78_12AF, 0,             ONE);

    // -pi/2 with ID and tlast passthrough
    send(32'hE6DE_04AC, 4'h5, 1'b1);
    check("hs_ready_low", bus.ing_tready, 0);
    wait_out(lat);
    check("neg_pi_half_lat", lat, 18);
    check("neg_pi_half_sin", sin_of(bus.egr_tdata), -ONE, TOL);
    check("neg_pi_half_cos", cos_of(bus.egr_tdata), 0, TOL);
    check("neg_pi_half_tid", bus.egr_tid, 5);
    check("neg_pi_half_tlast", bus.egr_tlast, 1);
    take();

    // Backpressure: hold egr_tready low for 10 cycles
    send(32'h1921_FB54, 4'h3, 1'b1);
    wait_out(lat);
    first = bus.egr_tdata;
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", bus.egr_tvalid, 1);
      check("bp_ing_ready", bus.ing_tready, 0);
      check("bp_sin", sin_of(bus.egr_tdata), ONE, TOL);
      check("bp_tid", bus.egr_tid, 3);
      check("bp_tlast", bus.egr_tlast, 1);
      @(posedge clk); #1;
    end
    check("bp_stable", longint'(bus.egr_tdata == first), 1);
    bus.egr_tready = 1'b1;
    bus.ing_tvalid = 1'b1;
    bus.ing_tdata  = 32'h0000_0000;
    bus.ing_tid    = 4'h4;
    bus.ing_tlast  = 1'b0;
    @(posedge clk); #1;
    bus.egr_tready = 1'b0;
    check("bp_release_valid", bus.egr_tvalid, 0);
    check("bp_release_ready", bus.ing_tready, 1);
    @(posedge clk); #1;
    check("bp_next_accepted", bus.ing_tready, 0);
    bus.ing_tvalid = 1'b0;
    wait_out(lat);
    check("bp_next_cos", cos_of(bus.egr_tdata), ONE, TOL);
    check("bp_next_tid", bus.egr_tid, 4);
    take();

    // Reset after the 5th rotation
    send(32'h1921_FB54, 4'h6, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ing_tready", bus.ing_tready, 0);
    check("mid_rst_egr_tvalid", bus.egr_tvalid, 0);
    check("mid_rst_egr_tdata", longint'(bus.egr_tdata != 64'd0), 0);
    check("mid_rst_egr_tid", bus.egr_tid, 0);
    check("mid_rst_egr_tlast", bus.egr_tlast, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready_back", bus.ing_tready, 1);
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.egr_tvalid) seen = 1;
    end
    check("mid_rst_no_egress", seen, 0);
    run_dir("post_rst_pi_half", 32'h1921_FB54, ONE, 0);

    // Random angles in [-2pi, 2pi) against a real-valued model, random backpressure
    for (int r = 0; r < 200; r++) begin
      longint      th;
      logic [31:0] th32;
      logic [3:0]  id;
      logic [63:0] data;
      logic [3:0]  rid;
      logic        got;
      int          w;
      real         a;
      th   = longint'($urandom_range(32'd3373259425, 32'd0)) - 64'sd1686629713;
      th32 = th[31:0];
      id   = 4'(r);
      send(th32, id, 1'b0);
      got  = 1'b0;
      w    = 0;
      data = '0;
      rid  = '0;
      while (!got && w < 200) begin
        bus.egr_tready = 1'($urandom_range(1, 0));
        if (bus.egr_tvalid && bus.egr_tready) begin
          data = bus.egr_tdata;
          rid  = bus.egr_tid;
          got  = 1'b1;
        end
        @(posedge clk); #1;
        w++;
      end
      bus.egr_tready = 1'b0;
      check("rnd_got", got, 1);
      a = real'(th) / 268435456.0;
      check("rnd_sin", sin_of(data), longint'($sin(a) * 268435456.0), TOL);
      check("rnd_cos", cos_of(data), longint'($cos(a) * 268435456.0), TOL);
      check("rnd_tid", rid, id);
    end

    @(posedge clk); #1;
    check("beat_count", beats, accepts - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
